// File: rtl/terrain_line_fetcher.sv
// Burst-fetches one scanline of 1bpp terrain mask words from OCM into a ping-pong
// line buffer; the renderer reads per-pixel bits from the front half.
module terrain_line_fetcher #(
  parameter int ADDR_W         = 11,
  parameter int WORDS_PER_LINE = 20,
  parameter int BASE_ADDR      = 0,
  parameter int RD_LAT         = 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              fetch_start,
  input  logic [8:0]        fetch_line,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd,
  input  logic [31:0]       mem_rdata,
  output logic              busy,
  output logic              done,
  output logic              overrun,
  input  logic              swap,
  input  logic [9:0]        pix_x,
  output logic              pix_out
);
  localparam int CW   = $clog2(WORDS_PER_LINE + 1);
  localparam int WW   = $clog2(WORDS_PER_LINE);
  localparam int NPIX = WORDS_PER_LINE * 32;

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

  state_t            state, nxt;
  logic [ADDR_W-1:0] start_addr, start_nxt;
  logic [CW-1:0]     issue_cnt, recv_cnt;
  logic              front, target;
  logic [RD_LAT:1]   vld_pipe;
  logic              wr_en;
  logic              in_range;
  logic [WW-1:0]     rd_word;
  logic [31:0]       line_buf [0:1][0:WORDS_PER_LINE-1];

  // Modular arithmetic at ADDR_W equals the full-width product truncated.
  assign start_nxt = ADDR_W'(BASE_ADDR) + ADDR_W'(fetch_line) * ADDR_W'(WORDS_PER_LINE);

  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) state <= IDLE;
    else          state <= nxt;

  always_comb begin
    nxt = state;
    case (state)
      IDLE:    if (fetch_start) nxt = ISSUE;
      ISSUE:   if (issue_cnt == CW'(WORDS_PER_LINE - 1)) nxt = DRAIN;
      DRAIN:   if (recv_cnt == CW'(WORDS_PER_LINE)) nxt = DONE;
      DONE:    nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  assign mem_rd   = (state == ISSUE);
  assign mem_addr = mem_rd ? start_addr + ADDR_W'(issue_cnt) : '0;
  assign busy     = (state != IDLE);
  assign done     = (state == DONE);
  assign wr_en    = vld_pipe[RD_LAT] && (state == ISSUE || state == DRAIN);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      start_addr <= '0;
      issue_cnt  <= '0;
      recv_cnt   <= '0;
      target     <= 1'b0;
      front      <= 1'b0;
      overrun    <= 1'b0;
      vld_pipe   <= '0;
    end else begin
      front    <= front ^ swap;
      overrun  <= fetch_start && busy;
      vld_pipe[1] <= mem_rd;
      for (int i = 2; i <= RD_LAT; i++) vld_pipe[i] <= vld_pipe[i-1];
      if (state == IDLE && fetch_start) begin
        start_addr <= start_nxt;
        target     <= ~front;  // back buffer as seen before any same-cycle swap
        issue_cnt  <= '0;
        recv_cnt   <= '0;
      end else begin
        if (state == ISSUE) issue_cnt <= issue_cnt + 1'b1;
        if (wr_en)          recv_cnt  <= recv_cnt + 1'b1;
      end
    end
  end

  // Line storage is never reset; a partially fetched line simply stays partial.
  always_ff @(posedge clk)
    if (wr_en) line_buf[target][recv_cnt[WW-1:0]] <= mem_rdata;

  assign in_range = {22'd0, pix_x} < 32'(NPIX);
  assign rd_word  = WW'(pix_x[9:5]);

  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) pix_out <= 1'b0;
    else          pix_out <= in_range ? line_buf[front][rd_word][pix_x[4:0]] : 1'b0;

endmodule

// File: tb/tb_terrain_line_fetcher.sv
// Scoreboard bench: two fetchers (RD_LAT 1 and 2) share stimulus, each with its own OCM model.
module tb_terrain_line_fetcher;
  logic        clk, reset_n, fetch_start, swap;
  logic [8:0]  fetch_line;
  logic [9:0]  pix_x;
  logic [10:0] addr1, addr2;
  logic        rd1, rd2, busy1, busy2, done1, done2, ovr1, ovr2, pix1, pix2;
  logic [31:0] rdata1, rdata2, d2a;

  int checks = 0;
  int passes = 0;
  int exp_q1[$];
  int exp_q2[$];
  logic pix_q[$];

  terrain_line_fetcher #(.RD_LAT(1)) dut1 (
    .clk(clk), .reset_n(reset_n), .fetch_start(fetch_start), .fetch_line(fetch_line),
    .mem_addr(addr1), .mem_rd(rd1), .mem_rdata(rdata1), .busy(busy1), .done(done1),
    .overrun(ovr1), .swap(swap), .pix_x(pix_x), .pix_out(pix1));

  terrain_line_fetcher #(.RD_LAT(2)) dut2 (
    .clk(clk), .reset_n(reset_n), .fetch_start(fetch_start), .fetch_line(fetch_line),
    .mem_addr(addr2), .mem_rd(rd2), .mem_rdata(rdata2), .busy(busy2), .done(done2),
    .overrun(ovr2), .swap(swap), .pix_x(pix_x), .pix_out(pix2));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Distinct, non-trivial word per address so pixel bits exercise all 32 positions.
  function automatic logic [31:0] ocm_val(input int a);
    logic [15:0] lo;
    lo = 16'(a);
    return {lo ^ 16'hBEEF, lo};
  endfunction

  always @(posedge clk) begin
    rdata1 <= ocm_val(int'(addr1));
    d2a    <= ocm_val(int'(addr2));
    rdata2 <= d2a;
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset_n = 1'b1;
    #1 reset_n = 1'b0;
    cyc();
    cyc();
    checks++;
    if ({busy1, done1, ovr1, rd1, addr1, pix1} !== 16'd0) begin
      $display("FAIL reset_dut1 got busy=%0b done=%0b ovr=%0b rd=%0b addr=%0d pix=%0b want all 0",
               busy1, done1, ovr1, rd1, addr1, pix1);
    end else passes++;
    checks++;
    if ({busy2, done2, ovr2, rd2, addr2, pix2} !== 16'd0) begin
      $display("FAIL reset_dut2 got busy=%0b done=%0b ovr=%0b rd=%0b addr=%0d pix=%0b want all 0",
               busy2, done2, ovr2, rd2, addr2, pix2);
    end else passes++;
    #2 reset_n = 1'b1;
    cyc();
  endtask

  // Full fetch of one line; ovr_at>0 injects a second fetch_start at that cycle.
  task automatic test_fetch(input int line, input int ovr_at);
    logic [3:0] exp1, exp2;
    exp_q1.delete();
    exp_q2.delete();
    for (int i = 0; i < 20; i++) begin
      exp_q1.push_back((line * 20 + i) % 2048);
      exp_q2.push_back((line * 20 + i) % 2048);
    end
    fetch_line  = 9'(line);
    fetch_start = 1'b1;
    cyc();
    fetch_start = 1'b0;
    for (int c = 1; c <= 26; c++) begin
      if (c == ovr_at) begin
        fetch_start = 1'b1;
        fetch_line  = 9'(line + 7);
      end
      exp1 = {c <= 20, c <= 23, c == 23, ovr_at > 0 && c == ovr_at + 1};
      exp2 = {c <= 20, c <= 24, c == 24, ovr_at > 0 && c == ovr_at + 1};
      checks++;
      if ({rd1, busy1, done1, ovr1} !== exp1) begin
        $display("FAIL ctrl1 line=%0d cyc=%0d got rd/busy/done/ovr=%b want %b",
                 line, c, {rd1, busy1, done1, ovr1}, exp1);
      end else passes++;
      checks++;
      if ({rd2, busy2, done2, ovr2} !== exp2) begin
        $display("FAIL ctrl2 line=%0d cyc=%0d got rd/busy/done/ovr=%b want %b",
                 line, c, {rd2, busy2, done2, ovr2}, exp2);
      end else passes++;
      if (rd1 === 1'b1) begin
        checks++;
        if (exp_q1.size() == 0) begin
          $display("FAIL addr1 cyc=%0d got extra strobe addr=%0d want none", c, addr1);
        end else begin
          int e;
          e = exp_q1.pop_front();
          if (int'(addr1) !== e) $display("FAIL addr1 cyc=%0d got %0d want %0d", c, addr1, e);
          else passes++;
        end
      end
      if (rd2 === 1'b1) begin
        checks++;
        if (exp_q2.size() == 0) begin
          $display("FAIL addr2 cyc=%0d got extra strobe addr=%0d want none", c, addr2);
        end else begin
          int e;
          e = exp_q2.pop_front();
          if (int'(addr2) !== e) $display("FAIL addr2 cyc=%0d got %0d want %0d", c, addr2, e);
          else passes++;
        end
      end
      cyc();
      fetch_start = 1'b0;
    end
    checks++;
    if (exp_q1.size() + exp_q2.size() != 0) begin
      $display("FAIL strobe_count line=%0d got %0d missing strobes want 0",
               line, exp_q1.size() + exp_q2.size());
    end else passes++;
  endtask

  // The buffer holding the given scanline is made front, then every pixel is swept.
  task automatic test_pixels(input int line);
    logic [31:0] w;
    logic        e;
    swap = 1'b1;
    cyc();
    swap = 1'b0;
    for (int x = 0; x <= 640; x++) begin
      int px;
      px = (x == 640) ? 700 : x;
      pix_x = 10'(px);
      if (px < 640) begin
        w = ocm_val(line * 20 + px / 32);
        pix_q.push_back(w[px % 32]);
      end else pix_q.push_back(1'b0);
      cyc();
      e = pix_q.pop_front();
      checks++;
      if (pix1 !== e) $display("FAIL pix1 x=%0d got %0b want %0b", px, pix1, e);
      else passes++;
      checks++;
      if (pix2 !== e) $display("FAIL pix2 x=%0d got %0b want %0b", px, pix2, e);
      else passes++;
    end
  endtask

  task automatic test_reset_mid_fetch();
    fetch_line  = 9'd3;
    fetch_start = 1'b1;
    cyc();
    fetch_start = 1'b0;
    for (int c = 1; c < 10; c++) cyc();
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if ({busy1, rd1, busy2, rd2} !== 4'b0000) begin
      $display("FAIL reset_mid got busy1/rd1/busy2/rd2=%b want 0000", {busy1, rd1, busy2, rd2});
    end else passes++;
    cyc();
    reset_n = 1'b1;
    cyc();
    test_fetch(5, 0);
  endtask

  initial begin
    fetch_start = 1'b0;
    fetch_line  = '0;
    swap        = 1'b0;
    pix_x       = '0;
    test_reset();
    test_fetch(1, 0);
    test_pixels(1);
    test_fetch(1, 5);
    test_fetch(102, 0);
    test_reset_mid_fetch();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
